pwl_delay_ctrl: RTL and testbench
=================================

# pwl_delay_ctrl

Clocked controller that produces the real-valued `delay` control consumed by the PWL delay primitive. It accepts a digital delay code through a valid/ready handshake and converts it to seconds as t_offset + code·t_lsb. The output moves toward the new target in bounded steps per clock, so the downstream delayed-write scheduling never sees a delay drop large enough to reorder PWL events. It reports busy/done around each update.

## Interface
- N, 8, code width (unsigned)
- t_lsb, 1e-12, delay per code LSB [s]
- t_offset, 10e-12, delay at code 0 [s]
- init_code, 0, code after reset
- step_up, 4, max LSB increase per clock (≥1)
- step_down, 1, max LSB decrease per clock (≥1)
- settle_cycles, 2, hold cycles after target reached (≥0)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- code_in  in  N  requested delay code
- code_valid  in  1  code_in valid
- code_ready  out  1  controller can accept a code
- code_cur  out  N  currently applied code (registered)
- delay  out  real  applied delay [s] = t_offset + code_cur·t_lsb
- busy  out  1  update in progress
- done  out  1  one-cycle pulse when update completes

## Operation
- Reset, sampled at clk edge with rst=1: state IDLE, code_cur=init_code, delay=t_offset+init_code·t_lsb, code_ready=1, busy=0, done=0, target=init_code, settle counter=0. Reset overrides all other activity, including mid-SLEW or mid-SETTLE. No done is issued for an aborted update.
- FSM states: IDLE, SLEW, SETTLE.
- IDLE:
  - code_ready=1, busy=0.
  - On an edge with code_valid&code_ready, latch target=code_in.
  - If target≠code_cur, go to SLEW.
  - Otherwise go to SETTLE with cnt=settle_cycles.
- SLEW:
  - Each edge: diff=target−code_cur, computed signed in N+1 bits.
  - If diff>0: code_cur += min(diff, step_up).
  - If diff<0: code_cur −= min(−diff, step_down).
  - When the updated code_cur equals target, go to SETTLE with cnt=settle_cycles.
  - code_cur never overshoots target and never wraps.
- SETTLE: each edge, if cnt==0 go to IDLE and assert done for one cycle; otherwise cnt−=1.
- code_ready=0 and busy=1 in SLEW and SETTLE. code_valid is ignored while code_ready=0, and code_in is not sampled.
- delay is recomputed from the registered code_cur and changes on the same edge as code_cur. It is never an unregistered function of code_in.
- done and code_ready are both high in the cycle after SETTLE exits. A code presented then is accepted at that edge, so back-to-back updates are possible.

## Timing
- Acceptance edge k. With n = number of SLEW steps (n = ceil(|diff|/step) using step_up or step_down as applicable; n=0 if equal):
  - code_cur changes on edges k+1 … k+n.
  - SETTLE occupies edges k+n+1 … k+n+settle_cycles+1.
  - done=1, code_ready=1, busy=0 in the cycle after edge k+n+settle_cycles+1.
- busy rises in the cycle after edge k.
- Output latency from code acceptance to first delay change: 1 clock.
- Maximum delay decrease per clock: step_down·t_lsb. Maximum increase per clock: step_up·t_lsb.

## Test plan
All scenarios use default parameters.
- Reset: hold rst=1 for 2 edges → code_cur=0, delay=10e-12, code_ready=1, busy=0, done=0.
- Up-slew: code_in=10 accepted at edge k → code_cur=4, 8, 10 after edges k+1, k+2, k+3; done pulse after edge k+6; delay=20e-12.
- Down-slew from 10: code_in=7 → code_cur=9, 8, 7 after edges k+1…k+3; done after edge k+6; no step exceeds 1 LSB.
- Equal code: code_in=code_cur=7 → code_cur and delay unchanged; busy for 3 cycles; done after edge k+3.
- Busy-ignore and back-to-back: code_in=255 held valid from the cycle after 7→10 is accepted → ignored until ready; accepted at the done cycle. From 10, 62 steps (last step 1) → code_cur=255, delay=265e-12, no wrap.
- Reset mid-slew: rst=1 during 0→200 slew at code_cur=40 → after that edge code_cur=0, delay=10e-12, state IDLE, done never pulses for the aborted update.

Source files
------------

// File: rtl/pwl_delay_ctrl.sv
// Delay-code controller for the PWL delay primitive: accepts a code, slews code_cur
// toward it in bounded steps so the downstream delay never drops fast enough to reorder events.
//
// state    | meaning
// S_IDLE   | ready for a new code, outputs stable
// S_SLEW   | stepping code_cur toward target each clock
// S_SETTLE | target reached, holding settle_cycles+1 clocks before done
module pwl_delay_ctrl #(
  parameter int  N             = 8,
  parameter real t_lsb         = 1e-12,
  parameter real t_offset      = 10e-12,
  parameter int  init_code     = 0,
  parameter int  step_up       = 4,
  parameter int  step_down     = 1,
  parameter int  settle_cycles = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] code_in,
  input  logic         code_valid,
  output logic         code_ready,
  output logic [N-1:0] code_cur,
  output real          delay,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] L_INIT   = init_code[N-1:0];
  localparam logic [N:0]   L_UP     = step_up[N:0];
  localparam logic [N:0]   L_DN     = step_down[N:0];
  localparam int           CW       = (settle_cycles > 0) ? $clog2(settle_cycles + 1) : 1;
  localparam logic [CW-1:0] L_SETTLE = settle_cycles[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_SLEW, S_SETTLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_code, w_code_nxt;
  logic [N-1:0]    r_target, w_target_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_done, w_done_nxt;
  logic signed [N:0] w_diff;
  logic [N:0]      w_mag;
  logic [N-1:0]    w_step;
  real             r_delay;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_code   <= L_INIT;
      r_target <= L_INIT;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_delay  <= t_offset + real'(L_INIT) * t_lsb;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
      // delay tracks the registered code on the same edge, never code_in directly
      r_delay  <= t_offset + real'(w_code_nxt) * t_lsb;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_diff       = $signed({1'b0, r_target}) - $signed({1'b0, r_code});
    w_mag        = w_diff[N] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_step       = '0;

    case (r_state)
      S_IDLE: begin
        if (code_valid) begin
          w_target_nxt = code_in;
          if (code_in != r_code) begin
            w_state_nxt = S_SLEW;
          end else begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = L_SETTLE;
          end
        end
      end
      S_SLEW: begin
        // step is clamped to the remaining distance, so no overshoot and no wrap
        if (w_diff[N]) begin
          w_step     = (w_mag < L_DN) ? w_mag[N-1:0] : L_DN[N-1:0];
          w_code_nxt = r_code - w_step;
        end else begin
          w_step     = (w_mag < L_UP) ? w_mag[N-1:0] : L_UP[N-1:0];
          w_code_nxt = r_code + w_step;
        end
        if (w_code_nxt == r_target) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = L_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign code_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign code_cur   = r_code;
  assign done       = r_done;
  assign delay      = r_delay;

endmodule

// File: tb/tb_pwl_delay_ctrl.sv
// Scoreboard bench for pwl_delay_ctrl: each accepted code pushes the expected per-cycle
// code_cur/busy/done trace, which is popped and compared on the falling edge.
module tb_pwl_delay_ctrl;

  localparam int SETTLE = 2;
  localparam int STEP_UP = 4;
  localparam int STEP_DN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [7:0] code_cur;
  real        delay_o;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] code;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         m_code = 0;

  pwl_delay_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_cur   (code_cur),
    .delay      (delay_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected trace for the cycles following the acceptance edge
  task push_update(input int tgt);
    int cur;
    cur = m_code;
    sb.push_back('{code: 8'(cur), busy: 1'b1, done: 1'b0});
    while (cur != tgt) begin
      if (tgt > cur) cur = cur + (((tgt - cur) < STEP_UP) ? (tgt - cur) : STEP_UP);
      else           cur = cur - (((cur - tgt) < STEP_DN) ? (cur - tgt) : STEP_DN);
      sb.push_back('{code: 8'(cur), busy: 1'b1, done: 1'b0});
    end
    for (int i = 0; i < SETTLE; i++) sb.push_back('{code: 8'(tgt), busy: 1'b1, done: 1'b0});
    sb.push_back('{code: 8'(tgt), busy: 1'b0, done: 1'b1});
    m_code = tgt;
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of the done cycle
  task test_update(input string name, input logic [7:0] code, input bit keep, input logic [7:0] nxt);
    exp_t e;
    real  ed;
    bit   first;
    checks++;
    if (code_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", name, code_ready);
    end
    code_in    = code;
    code_valid = 1'b1;
    push_update(int'(code));
    @(posedge clk);
    first = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      if (first) begin
        if (keep) code_in = nxt;
        else      code_valid = 1'b0;
        first = 1'b0;
      end
      e  = sb.pop_front();
      ed = 10e-12 + real'(e.code) * 1e-12;
      checks++;
      if (code_cur !== e.code) begin
        errors++;
        $display("FAIL %s code_cur: got %0d want %0d", name, code_cur, e.code);
      end
      checks++;
      if (busy !== e.busy || code_ready !== !e.busy) begin
        errors++;
        $display("FAIL %s busy/ready: got %b/%b want %b/%b", name, busy, code_ready, e.busy, !e.busy);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("FAIL %s done: got %b want %b", name, done, e.done);
      end
      checks++;
      if (delay_o - ed > 1e-16 || ed - delay_o > 1e-16) begin
        errors++;
        $display("FAIL %s delay: got %e want %e", name, delay_o, ed);
      end
    end
  endtask

  task test_reset;
    rst = 1'b1;
    code_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (code_cur !== 8'd0 || code_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got code=%0d rdy=%b busy=%b done=%b want 0/1/0/0",
               code_cur, code_ready, busy, done);
    end
    checks++;
    if (delay_o - 10e-12 > 1e-16 || 10e-12 - delay_o > 1e-16) begin
      errors++;
      $display("FAIL reset delay: got %e want %e", delay_o, 10e-12);
    end
    rst = 1'b0;
    m_code = 0;
  endtask

  task test_reset_midslew;
    exp_t e;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_code = 0;
    sb.delete();
    code_in = 8'd200;
    code_valid = 1'b1;
    sb.push_back('{code: 8'd0, busy: 1'b1, done: 1'b0});
    for (int c = 4; c <= 40; c += 4) sb.push_back('{code: 8'(c), busy: 1'b1, done: 1'b0});
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (code_cur !== e.code || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL midslew trace: got %0d/%b/%b want %0d/%b/%b",
                 code_cur, busy, done, e.code, e.busy, e.done);
      end
      if (sb.size() > 0) @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (code_cur !== 8'd0 || code_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midslew reset: got code=%0d rdy=%b busy=%b done=%b want 0/1/0/0",
               code_cur, code_ready, busy, done);
    end
    checks++;
    if (delay_o - 10e-12 > 1e-16 || 10e-12 - delay_o > 1e-16) begin
      errors++;
      $display("FAIL midslew delay: got %e want %e", delay_o, 10e-12);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || code_cur !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_done cycle %0d: got done=%b code=%0d busy=%b want 0/0/0",
                 i, done, code_cur, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_update("up_slew", 8'd10, 1'b0, 8'd0);
    test_update("down_slew", 8'd7, 1'b0, 8'd0);
    test_update("equal_code", 8'd7, 1'b0, 8'd0);
    test_update("busy_ignore", 8'd10, 1'b1, 8'd255);
    test_update("back_to_back", 8'd255, 1'b0, 8'd0);
    test_reset_midslew();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
